// File: rtl/servo_pwm_capture_pkg.sv
// Shared constants and types for the servo PWM capture/generation blocks.
package servo_pwm_capture_pkg;

  localparam int unsigned CLK_HZ          = 26_000_000;
  localparam int unsigned DEFAULT_CNT_W   = 24;
  // About 40 ms at 26 MHz: two missed 50 Hz frames.
  localparam int unsigned DEFAULT_TIMEOUT = 1_048_576;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } cap_state_e;

endpackage

// File: rtl/servo_pwm_capture_filter.sv
// Pin conditioning: two-flop synchronizer, FILT_LEN-sample deglitch and
// single-cycle rise/fall pulses aligned with the filtered level change.
module servo_pwm_capture_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       level_q, level_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       rise_q, fall_q;

  // Toggle only after FILT_LEN consecutive deviating samples; any agreeing
  // sample restarts the count.
  always_comb begin
    level_d = level_q;
    fcnt_d  = '0;
    if (sync_q[1] != level_q) begin
      if (fcnt_q == 4'(FILT_LEN - 1)) begin
        level_d = ~level_q;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  // Synchronizer, filter state and edge pulses.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      fcnt_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sig_i};
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures rise-to-rise period and high width in clk cycles,
// strobes each completed period and flags loss of signal.
module servo_pwm_capture
  import servo_pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W    = DEFAULT_CNT_W,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             pwm_in_i,
  output logic [CNT_W-1:0] period_meas_o,
  output logic [CNT_W-1:0] pulse_meas_o,
  output logic             meas_valid_o,
  output logic             signal_lost_o,
  output logic             pwm_level_o
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic rise, fall, timeout;
  cap_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] pulse_tmp_q, pulse_tmp_d;
  logic [CNT_W-1:0] period_q, period_d, pulse_q, pulse_d;
  logic valid_q, valid_d, lost_q, lost_d;

  servo_pwm_capture_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .sig_i   (pwm_in_i),
    .level_o (pwm_level_o),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign timeout = (cnt_q == TimeoutVal);
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next state: disable dominates, then edges, then timeout.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (rise) state_d = StHigh;
        StHigh:  if (fall) state_d = StLow;  else if (timeout) state_d = StIdle;
        StLow:   if (rise) state_d = StHigh; else if (timeout) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath and outputs: counter, width latch, result update and loss flag.
  always_comb begin
    cnt_d       = cnt_q;
    pulse_tmp_d = pulse_tmp_q;
    period_d    = period_q;
    pulse_d     = pulse_q;
    valid_d     = 1'b0;
    lost_d      = lost_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: cnt_d = rise ? CntOne : '0;
        StHigh: begin
          if (fall) begin
            pulse_tmp_d = cnt_q;
            cnt_d       = cnt_inc;
          end else if (timeout) begin
            lost_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StLow: begin
          if (rise) begin
            period_d = cnt_q;
            pulse_d  = pulse_tmp_q;
            valid_d  = 1'b1;
            lost_d   = 1'b0;
            cnt_d    = CntOne;
          end else if (timeout) begin
            lost_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Measurement registers; loss flag resets set because no signal is seen yet.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q       <= '0;
      pulse_tmp_q <= '0;
      period_q    <= '0;
      pulse_q     <= '0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      pulse_tmp_q <= pulse_tmp_d;
      period_q    <= period_d;
      pulse_q     <= pulse_d;
      valid_q     <= valid_d;
      lost_q      <= lost_d;
    end
  end

  assign period_meas_o = period_q;
  assign pulse_meas_o  = pulse_q;
  assign meas_valid_o  = valid_q;
  assign signal_lost_o = lost_q;

endmodule
